// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
// Optional bounce counter is enabled by defining DEBOUNCE_GLITCH_CNT_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW    = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } db_state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int GLITCH_W          = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous level; resets to 1 so an
// active-low input reads as released while in reset.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '1;
    else        ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer: synchronizer followed by a four-state accept FSM.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module key_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_n,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  output logic [GLITCH_W-1:0] glitch_cnt,
`endif
  output logic                out
);

  localparam int              CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          key_sync;
  logic          s;
  db_state_t     state;
  logic [CW-1:0] cnt;

  sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (key_n),
    .q     (key_sync)
  );

  assign s = ~key_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE_LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            cnt   <= CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            cnt   <= CW'(1);
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Pressed level is a pure decode of the state flops.
  assign out = (state == STABLE_HIGH) || (state == WAIT_LOW);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic reject;

  assign reject = ((state == WAIT_HIGH) && !s) || ((state == WAIT_LOW) && s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          glitch_cnt <= '0;
    else if (reject && (glitch_cnt != '1)) glitch_cnt <= glitch_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer (SYNC_STAGES=2, STABLE_CYCLES=4).
// glitch_cnt checks are active when DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_key_debouncer;
  import debounce_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic out;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_gl = 0;
  logic held;

  key_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
`ifdef DEBOUNCE_GLITCH_CNT_EN
    .glitch_cnt (glitch_cnt),
`endif
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_gl(input string tag);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk(tag, 32'(glitch_cnt), 32'(exp_gl));
`endif
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance n edges and require out to hold val after each one.
  task automatic hold_chk(input string tag, input int n, input logic val);
    held = 1'b1;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (out !== val) held = 1'b0;
    end
    chk(tag, 32'(held), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    key_n = 1'b1;
    #2;
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_state", 32'(dut.state), 32'(IDLE_LOW));
    chk_gl("reset_glitch");
    step(1);
    reset = 1'b1;
    step(2);

    // Press held: out rises on the 6th sampling edge.
    key_n = 1'b0;
    step(5);
    chk("press_lat5", 32'(out), 32'd0);
    step(1);
    chk("press_lat6", 32'(out), 32'd1);
    chk_gl("press_glitch");

    // Release bounces while pressed: two rejections, out never drops.
    key_n = 1'b1; step(1);
    key_n = 1'b0; step(1);
    key_n = 1'b1; step(1);
    key_n = 1'b0; step(1);
    hold_chk("rel_bounce_hold", 8, 1'b1);
    exp_gl += 2;
    chk_gl("rel_bounce_glitch");

    // Release held: out falls on the 6th sampling edge.
    key_n = 1'b1;
    step(5);
    chk("release_lat5", 32'(out), 32'd1);
    step(1);
    chk("release_lat6", 32'(out), 32'd0);

    // Two-sample press bounce rejected.
    key_n = 1'b0; step(2);
    key_n = 1'b1;
    hold_chk("bounce2_hold", 6, 1'b0);
    exp_gl += 1;
    chk_gl("bounce2_glitch");

    // Three-sample press (STABLE_CYCLES-1) still rejected.
    key_n = 1'b0; step(3);
    key_n = 1'b1;
    hold_chk("bounce3_hold", 6, 1'b0);
    exp_gl += 1;
    chk_gl("bounce3_glitch");

    // Four-sample press accepted, then released after full latency.
    key_n = 1'b0; step(4);
    key_n = 1'b1; step(2);
    chk("pulse4_accept", 32'(out), 32'd1);
    step(10);
    chk("pulse4_release", 32'(out), 32'd0);
    chk_gl("pulse4_glitch");

    // Async reset while pressed clears out before the next edge.
    key_n = 1'b0;
    step(6);
    chk("pre_reset_out", 32'(out), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("async_reset_out", 32'(out), 32'd0);
    chk("async_reset_state", 32'(dut.state), 32'(IDLE_LOW));
    exp_gl = 0;
    chk_gl("async_reset_glitch");
    step(1);
    reset = 1'b1;
    step(5);
    chk("post_reset_lat5", 32'(out), 32'd0);
    step(1);
    chk("post_reset_lat6", 32'(out), 32'd1);

    // Reset during a press in progress discards it.
    key_n = 1'b1;
    step(8);
    key_n = 1'b0;
    step(4);
    chk("midpress_state", 32'(dut.state), 32'(WAIT_HIGH));
    reset = 1'b0;
    #1;
    chk("midpress_reset_state", 32'(dut.state), 32'(IDLE_LOW));
    step(1);
    reset = 1'b1;
    step(5);
    chk("midpress_lat5", 32'(out), 32'd0);
    step(1);
    chk("midpress_lat6", 32'(out), 32'd1);

    // Many rejected bounces saturate the glitch counter.
    key_n = 1'b1;
    step(8);
    chk("sat_idle", 32'(out), 32'd0);
    held = 1'b1;
    for (int i = 0; i < 300; i++) begin
      key_n = 1'b0; step(2);
      key_n = 1'b1; step(4);
      if (out !== 1'b0) held = 1'b0;
      if (exp_gl < 255) exp_gl++;
    end
    chk("sat_out_low", 32'(held), 32'd1);
    chk_gl("sat_glitch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
